// File: rtl/alu_execute_stage.sv
// Execute stage for a 4-bit ALU. Single-cycle logic/arith ops complete in one cycle;
// MULT (shift-add) and DIV (restoring) iterate for four BUSY cycles before DONE.
module alu_execute_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       In_Valid,
  output logic       In_Ready,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Enable_AND,
  input  logic       Enable_NAND,
  input  logic       Enable_OR,
  input  logic       Enable_NOR,
  input  logic       Enable_XOR,
  input  logic       Enable_XNOR,
  input  logic       Enable_NOT,
  input  logic       Enable_ADD,
  input  logic       Enable_SUB,
  input  logic       Enable_MULT,
  input  logic       Enable_DIV,
  input  logic       Enable_SHIFT,
  output logic       Out_Valid,
  input  logic       Out_Ready,
  output logic [7:0] Result,
  output logic       Carry,
  output logic       Zero,
  output logic       Error
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_isDiv;
  logic [1:0] r_iter;
  logic [7:0] r_prod;
  logic [4:0] r_rem;
  logic [3:0] r_quo;

  logic [11:0] w_en;
  logic        w_oneHot;
  logic        w_iterative;
  logic [4:0]  w_sum;
  logic [7:0]  w_result;
  logic        w_carry;
  logic        w_error;
  logic [7:0]  w_addend;
  logic [7:0]  w_nextProd;
  logic [4:0]  w_shift;
  logic [5:0]  w_diff;
  logic        w_fits;
  logic [4:0]  w_nextRem;
  logic [3:0]  w_nextQuo;
  logic [7:0]  w_iterResult;

  assign w_en = {Enable_SHIFT, Enable_DIV, Enable_MULT, Enable_SUB, Enable_ADD, Enable_NOT,
                 Enable_XNOR, Enable_XOR, Enable_NOR, Enable_OR, Enable_NAND, Enable_AND};
  assign w_oneHot    = (w_en != 12'd0) && ((w_en & (w_en - 12'd1)) == 12'd0);
  assign w_iterative = w_oneHot && (Enable_MULT || (Enable_DIV && (B != 4'd0)));
  assign w_sum       = {1'b0, A} + {1'b0, B};

  assign In_Ready = (r_state == IDLE);

  // Result of every op that finishes at the accept edge, taken straight from the inputs.
  always_comb begin
    w_result = 8'h00;
    w_carry  = 1'b0;
    w_error  = 1'b0;
    if (!w_oneHot) begin
      w_error = 1'b1;
    end else begin
      case (w_en)
        12'h001: w_result = {4'h0, A & B};
        12'h002: w_result = {4'h0, ~(A & B)};
        12'h004: w_result = {4'h0, A | B};
        12'h008: w_result = {4'h0, ~(A | B)};
        12'h010: w_result = {4'h0, A ^ B};
        12'h020: w_result = {4'h0, ~(A ^ B)};
        12'h040: w_result = {4'h0, ~A};
        12'h080: begin
          w_result = {4'h0, w_sum[3:0]};
          w_carry  = w_sum[4];
        end
        12'h100: begin
          w_result = {4'h0, A - B};
          w_carry  = (A < B);
        end
        12'h400: begin
          w_result = 8'hFF;
          w_error  = 1'b1;
        end
        12'h800: w_result = {4'h0, A} << B[1:0];
        default: w_result = 8'h00;
      endcase
    end
  end

  assign w_addend   = r_b[r_iter] ? ({4'h0, r_a} << r_iter) : 8'h00;
  assign w_nextProd = r_prod + w_addend;

  // Remainder stays below the divisor, so its low nibble plus the next dividend bit fits in 5 bits.
  assign w_shift      = {r_rem[3:0], r_quo[3]};
  assign w_diff       = {1'b0, w_shift} - {2'b00, r_b};
  assign w_fits       = ~w_diff[5];
  assign w_nextRem    = w_fits ? w_diff[4:0] : w_shift;
  assign w_nextQuo    = {r_quo[2:0], w_fits};
  assign w_iterResult = r_isDiv ? {w_nextRem[3:0], w_nextQuo} : w_nextProd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      Out_Valid <= 1'b0;
      Result    <= 8'h00;
      Carry     <= 1'b0;
      Zero      <= 1'b0;
      Error     <= 1'b0;
      r_a       <= 4'd0;
      r_b       <= 4'd0;
      r_isDiv   <= 1'b0;
      r_iter    <= 2'd0;
      r_prod    <= 8'h00;
      r_rem     <= 5'd0;
      r_quo     <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (In_Valid) begin
            r_a     <= A;
            r_b     <= B;
            r_isDiv <= Enable_DIV;
            r_iter  <= 2'd0;
            r_prod  <= 8'h00;
            r_rem   <= 5'd0;
            r_quo   <= A;
            if (w_iterative) begin
              r_state <= BUSY;
            end else begin
              r_state   <= DONE;
              Out_Valid <= 1'b1;
              Result    <= w_result;
              Carry     <= w_carry;
              Zero      <= (w_result == 8'h00);
              Error     <= w_error;
            end
          end
        end
        BUSY: begin
          r_iter <= r_iter + 2'd1;
          if (r_isDiv) begin
            r_rem <= w_nextRem;
            r_quo <= w_nextQuo;
          end else begin
            r_prod <= w_nextProd;
          end
          if (r_iter == 2'd3) begin
            r_state   <= DONE;
            Out_Valid <= 1'b1;
            Result    <= w_iterResult;
            Carry     <= 1'b0;
            Zero      <= (w_iterResult == 8'h00);
            Error     <= 1'b0;
          end
        end
        DONE: begin
          if (Out_Ready) begin
            r_state   <= IDLE;
            Out_Valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          Out_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Bench for alu_execute_stage: directed corner cases followed by random operations,
// each compared against an arithmetic reference model.
module tb_alu_execute_stage;

  localparam int AND_I = 0, NAND_I = 1, OR_I = 2, NOR_I = 3, XOR_I = 4, XNOR_I = 5;
  localparam int NOT_I = 6, ADD_I = 7, SUB_I = 8, MULT_I = 9, DIV_I = 10, SHIFT_I = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic        In_Valid;
  logic        In_Ready;
  logic [3:0]  A;
  logic [3:0]  B;
  logic [11:0] en;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [7:0]  Result;
  logic        Carry;
  logic        Zero;
  logic        Error;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_execute_stage dut (
    .clk         (clk),
    .reset       (reset),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .A           (A),
    .B           (B),
    .Enable_AND  (en[AND_I]),
    .Enable_NAND (en[NAND_I]),
    .Enable_OR   (en[OR_I]),
    .Enable_NOR  (en[NOR_I]),
    .Enable_XOR  (en[XOR_I]),
    .Enable_XNOR (en[XNOR_I]),
    .Enable_NOT  (en[NOT_I]),
    .Enable_ADD  (en[ADD_I]),
    .Enable_SUB  (en[SUB_I]),
    .Enable_MULT (en[MULT_I]),
    .Enable_DIV  (en[DIV_I]),
    .Enable_SHIFT(en[SHIFT_I]),
    .Out_Valid   (Out_Valid),
    .Out_Ready   (Out_Ready),
    .Result      (Result),
    .Carry       (Carry),
    .Zero        (Zero),
    .Error       (Error)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic void refModel(input logic [3:0] a, input logic [3:0] b, input logic [11:0] e,
                                   output logic [7:0] res, output logic c, output logic err,
                                   output int lat);
    int ia;
    int ib;
    ia  = int'(a);
    ib  = int'(b);
    res = 8'h00;
    c   = 1'b0;
    err = 1'b0;
    lat = 1;
    if ($countones(e) != 1) begin
      err = 1'b1;
      return;
    end
    if (e[AND_I])   res = {4'h0, a & b};
    if (e[NAND_I])  res = {4'h0, ~(a & b)};
    if (e[OR_I])    res = {4'h0, a | b};
    if (e[NOR_I])   res = {4'h0, ~(a | b)};
    if (e[XOR_I])   res = {4'h0, a ^ b};
    if (e[XNOR_I])  res = {4'h0, ~(a ^ b)};
    if (e[NOT_I])   res = {4'h0, ~a};
    if (e[ADD_I]) begin
      res = 8'((ia + ib) % 16);
      c   = (ia + ib) > 15;
    end
    if (e[SUB_I]) begin
      res = 8'((ia - ib + 16) % 16);
      c   = ia < ib;
    end
    if (e[MULT_I]) begin
      res = 8'(ia * ib);
      lat = 5;
    end
    if (e[DIV_I]) begin
      if (ib == 0) begin
        res = 8'hFF;
        err = 1'b1;
      end else begin
        res = 8'((ia % ib) * 16 + ia / ib);
        lat = 5;
      end
    end
    if (e[SHIFT_I]) res = 8'(ia * (1 << (ib % 4)));
  endfunction

  // Issues one operation, scrambles the inputs after the accept edge, then checks
  // latency, the result, that it holds for 'hold' stalled cycles, and the release.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [11:0] e,
                               input int hold);
    logic [7:0] expRes;
    logic       expC;
    logic       expE;
    int         expLat;
    int         cycles;
    refModel(a, b, e, expRes, expC, expE, expLat);
    checkOutput("in_ready_idle", In_Ready, 1);
    A        = a;
    B        = b;
    en       = e;
    In_Valid = 1'b1;
    @(posedge clk); #1;
    cycles   = 1;
    A        = 4'($urandom);
    B        = 4'($urandom);
    en       = 12'($urandom);
    In_Valid = 1'($urandom);
    while (!Out_Valid && cycles < 20) begin
      checkOutput("in_ready_busy", In_Ready, 0);
      Out_Ready = 1'($urandom);
      @(posedge clk); #1;
      Out_Ready = 1'b0;
      cycles++;
      A = 4'($urandom);
      B = 4'($urandom);
    end
    checkOutput("latency", 8'(cycles), 8'(expLat));
    checkOutput("in_ready_done", In_Ready, 0);
    checkOutput("result", Result, expRes);
    checkOutput("carry", Carry, expC);
    checkOutput("zero", Zero, expRes == 8'h00);
    checkOutput("error", Error, expE);
    for (int k = 0; k < hold; k++) begin
      In_Valid = 1'($urandom);
      @(posedge clk); #1;
      checkOutput("hold_valid", Out_Valid, 1);
      checkOutput("hold_result", Result, expRes);
      checkOutput("hold_carry", Carry, expC);
      checkOutput("hold_error", Error, expE);
    end
    Out_Ready = 1'b1;
    @(posedge clk); #1;
    Out_Ready = 1'b0;
    In_Valid  = 1'b0;
    checkOutput("release_valid", Out_Valid, 0);
    checkOutput("release_in_ready", In_Ready, 1);
  endtask

  initial begin
    reset     = 1'b1;
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
    A         = 4'd0;
    B         = 4'd0;
    en        = 12'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", In_Ready, 1);
    checkOutput("rst_out_valid", Out_Valid, 0);
    checkOutput("rst_result", Result, 8'h00);
    checkOutput("rst_carry", Carry, 0);
    checkOutput("rst_zero", Zero, 0);
    checkOutput("rst_error", Error, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", In_Ready, 1);

    applyStimulus(4'hF, 4'h1, 12'(1) << ADD_I, 0);
    applyStimulus(4'hF, 4'hF, 12'(1) << MULT_I, 1);
    applyStimulus(4'hD, 4'h4, 12'(1) << DIV_I, 0);
    applyStimulus(4'h7, 4'h0, 12'(1) << DIV_I, 0);
    applyStimulus(4'h2, 4'h5, 12'(1) << SUB_I, 3);
    applyStimulus(4'h9, 4'h3, (12'(1) << AND_I) | (12'(1) << OR_I), 0);
    applyStimulus(4'h9, 4'h3, 12'd0, 1);
    applyStimulus(4'hF, 4'hF, 12'hFFF, 0);
    applyStimulus(4'h0, 4'h9, 12'(1) << DIV_I, 0);
    applyStimulus(4'h0, 4'h7, 12'(1) << MULT_I, 0);
    applyStimulus(4'h9, 4'hE, 12'(1) << SHIFT_I, 0);

    for (int i = 0; i < 12; i++)
      applyStimulus(4'($urandom), 4'($urandom), 12'(1) << i, int'($urandom_range(0, 2)));

    // Reset lands in the second BUSY cycle of a MULT; nothing may surface afterwards.
    A        = 4'hF;
    B        = 4'hF;
    en       = 12'(1) << MULT_I;
    In_Valid = 1'b1;
    @(posedge clk); #1;
    In_Valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_in_ready", In_Ready, 1);
    checkOutput("abort_out_valid", Out_Valid, 0);
    checkOutput("abort_result", Result, 8'h00);
    checkOutput("abort_zero", Zero, 0);
    for (int k = 0; k < 6; k++) begin
      Out_Ready = 1'($urandom);
      @(posedge clk); #1;
      checkOutput("abort_no_stale", Out_Valid, 0);
      checkOutput("abort_idle", In_Ready, 1);
    end
    Out_Ready = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [11:0] e;
      if ($urandom_range(0, 3) != 0) e = 12'(1) << $urandom_range(0, 11);
      else                           e = 12'($urandom);
      applyStimulus(4'($urandom), 4'($urandom), e, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
